// File: rtl/turn_queue.sv
// turn_queue: queues legal snake turns from button pulses and releases one per game step
// Ports:
//   clk_i, rst_i            debouncer clock, synchronous active-high reset
//   up/down/left/right_i    single-cycle debounced direction pulses
//   center_pressed_i        single-cycle pulse toggling pause
//   tick_i                  one-cycle game-step strobe
//   game_over_i             level; freezes Dir and flushes queue and pause
//   dir_o                   committed heading (UP=00 DOWN=01 LEFT=10 RIGHT=11)
//   paused_o                pause state
//   pending_o               number of queued turns
//   dropped_o               one-cycle pulse after a rejected press
module turn_queue #(
   parameter int         DEPTH    = 2,
   parameter logic [1:0] INIT_DIR = 2'b11
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       up_pressed_i,
   input  logic                       down_pressed_i,
   input  logic                       left_pressed_i,
   input  logic                       right_pressed_i,
   input  logic                       center_pressed_i,
   input  logic                       tick_i,
   input  logic                       game_over_i,
   output logic [1:0]                 dir_o,
   output logic                       paused_o,
   output logic [$clog2(DEPTH+1)-1:0] pending_o,
   output logic                       dropped_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [1:0]    mem_q [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, last;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    dir_q, dir_d, press, ref_dir;
   logic          paused_q, paused_d, dropped_q, dropped_d;
   logic          any, active, pop, push, opp, eval_en;
   always_comb begin
      any       = up_pressed_i | down_pressed_i | left_pressed_i | right_pressed_i;
      press     = up_pressed_i ? 2'b00 : down_pressed_i ? 2'b01 : left_pressed_i ? 2'b10 : 2'b11;
      last      = wr_q - 1'b1;
      // reversals are judged against the newest queued turn, not just the live heading
      ref_dir   = (cnt_q != '0) ? mem_q[last] : dir_q;
      active    = !game_over_i && !paused_q;
      pop       = active && tick_i && (cnt_q != '0);
      opp       = (press[1] == ref_dir[1]) && (press[0] != ref_dir[0]);
      eval_en   = active && any && (press != ref_dir);
      // a full queue still accepts when the head leaves on the same edge
      dropped_d = eval_en && (opp || ((cnt_q == CW'(DEPTH)) && !pop));
      push      = eval_en && !dropped_d;
      rd_d      = game_over_i ? '0 : rd_q + PW'(pop);
      wr_d      = game_over_i ? '0 : wr_q + PW'(push);
      cnt_d     = game_over_i ? '0 : cnt_q + CW'(push) - CW'(pop);
      dir_d     = pop ? mem_q[rd_q] : dir_q;
      paused_d  = game_over_i ? 1'b0 : paused_q ^ center_pressed_i;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q      <= '0;
         wr_q      <= '0;
         cnt_q     <= '0;
         dir_q     <= INIT_DIR;
         paused_q  <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         paused_q  <= paused_d;
         dropped_q <= dropped_d;
      end
   end
   always_ff @(posedge clk_i)
      if (!rst_i && push) mem_q[wr_q] <= press;
   assign dir_o     = dir_q;
   assign paused_o  = paused_q;
   assign pending_o = cnt_q;
   assign dropped_o = dropped_q;
endmodule

// File: doc/turn_queue.md
# turn_queue

Buffers debounced button presses into a short queue of legal snake turns and releases exactly one turn per game step. It sits between the five button debouncers and the snake game core. It rejects 180° reversals against the most recent committed or queued heading, and owns the pause state toggled by the centre button. All logic runs on the debouncer clock; the game core supplies a one-cycle step strobe in the same domain.

## Interface
- DEPTH, 2, maximum queued turns; power of two, ≥2
- INIT_DIR, 2'b11, heading after reset (RIGHT)

Direction encoding is fixed for this block: UP=2'b00, DOWN=2'b01, LEFT=2'b10, RIGHT=2'b11.

- Clock  in  1  debouncer clock; all state on posedge
- Reset  in  1  synchronous, active-high
- UpPressed / DownPressed / LeftPressed / RightPressed  in  1 each  single-cycle debounced pulses
- CenterPressed  in  1  single-cycle pulse; toggles pause
- Tick  in  1  one-cycle game-step strobe from the game core
- GameOver  in  1  level; freezes and flushes the block
- Dir  out  2  committed heading for the current step
- Paused  out  1  pause state
- Pending  out  $clog2(DEPTH+1)  number of queued turns
- Dropped  out  1  one-cycle pulse: a press was rejected

## Operation
- Reset: Dir=INIT_DIR, Paused=0, Pending=0, Dropped=0, read/write pointers=0. Reset overrides all other inputs.
- Reference heading (Ref) = newest queue entry if Pending>0, else Dir.
- Multiple directional pulses in the same cycle: priority Up>Down>Left>Right. Only the winner is evaluated. Losers are ignored without Dropped.
- Opposite test: a[1]==b[1] && a[0]!=b[0].
- Directional press, with GameOver=0 and Paused=0:
  - press == Ref: ignored silently.
  - press opposite Ref: rejected, Dropped=1.
  - queue full and no pop this cycle: rejected, Dropped=1.
  - otherwise: pushed at the tail.
- Pop: on Tick with GameOver=0, Paused=0 and Pending>0, the head moves into Dir and is removed. Tick with an empty queue leaves Dir unchanged.
- Simultaneous push and pop: both occur and Pending is unchanged. A push into a full queue is allowed if a pop happens in the same cycle. Ref is evaluated from pre-edge state.
- CenterPressed with GameOver=0 toggles Paused. It is evaluated in parallel with a directional press in the same cycle; that press uses the pre-edge Paused value.
- While Paused=1: directional presses are ignored silently (no Dropped), Tick is ignored, and queue contents are retained.
- GameOver=1: every cycle Pending←0, Paused←0, Dropped←0. All presses and Tick are ignored, and Dir holds.
- Pointers wrap modulo DEPTH. Pending saturates at 0 and DEPTH by construction and never over- or underflows.

## Timing
- All outputs are registered.
- Dir changes on the Tick edge. The game core samples Dir in the cycle after it asserts Tick (latency 1).
- Dropped asserts in the cycle after the rejected press, for exactly one cycle.
- Pending reflects a push or pop in the cycle after the event.
- Paused toggles in the cycle after CenterPressed.
- No combinational path from any input to any output.

## Test plan
- Reset, then RightPressed → no change (equals Ref); UpPressed → Pending=1; Tick → next cycle Dir=00, Pending=0.
- Dir=11, Pending=0: LeftPressed → Dropped pulses 1 cycle, Pending=0. Then UpPressed followed by LeftPressed → Pending=2, queue {00,10}. Two Ticks → Dir=00, then Dir=10.
- DEPTH=2 with queue {00,10}: DownPressed → Dropped, since the queue is full. Repeat DownPressed in the same cycle as Tick → accepted: Dir=00, queue {10,01}, Pending=2.
- CenterPressed → Paused=1. UpPressed and Tick → no Dropped, Dir and Pending unchanged. CenterPressed → Paused=0.
- Up and Left pulsed together with Dir=11 → only Up is queued, Pending=1. GameOver=1 for 1 cycle → Pending=0, Dir unchanged.
- Reset asserted with Pending=2 and Paused=1 → next cycle Dir=11, Pending=0, Paused=0, Dropped=0.
